// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART transmitter and receiver.
//   uart_state_t     : frame state encoding (IDLE, START, DATA, STOP)
//   DEFAULT_CLK_FREQ : default system clock frequency in Hz
//   DEFAULT_BAUD     : default line baud rate
//   DATA_BITS        : payload bits per frame (8N1)
//   calc_div()       : clock cycles per bit for a given clock/baud pair
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_t;

   localparam int DEFAULT_CLK_FREQ = 100_000_000;
   localparam int DEFAULT_BAUD     = 9600;
   localparam int DATA_BITS        = 8;

   // Integer truncation is intended: the bit period is rounded down.
   function automatic int calc_div(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// baud_tick -- bit-period counter for the UART transmitter.
//   clk      : system clock, rising edge
//   rst      : synchronous active-low reset
//   clr      : synchronous clear, holds the count at 0 while high
//   tick     : high while the count is DIV-1 (last cycle of a bit)
//   pre_tick : high while the count is DIV-2 (one cycle before tick), lets
//              the parent register an output that must be high on the last cycle
// DIV must be at least 2.
module baud_tick #(
   parameter int DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick,
   output logic pre_tick
);

   localparam int CNT_W = $clog2(DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIV - 2);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg <= '0;
      end else if (clr || cnt_reg == CNT_LAST) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign tick     = (cnt_reg == CNT_LAST);
   assign pre_tick = (cnt_reg == CNT_PRE);

endmodule

// File: rtl/uart_tx.sv
// uart_tx -- byte-serial UART transmitter, 8N1, LSB first.
//   clk   : system clock, rising edge
//   rst   : synchronous active-low reset
//   valid : upstream offers the byte on data
//   data  : byte to send, sampled only on accept (valid & ready)
//   ready : registered, high while idle and able to accept
//   tx    : registered serial line, idles high
//   done  : registered one-cycle pulse on the last cycle of the stop bit
// Every output register is loaded with the value the line must show during
// the coming cycle, so tx falls in the cycle right after the accepting edge.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
   parameter int BAUD     = DEFAULT_BAUD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       valid,
   input  logic [7:0] data,
   output logic       ready,
   output logic       tx,
   output logic       done
);

   // Derived only; overriding it separately from CLK_FREQ/BAUD is not allowed.
   localparam int DIV = calc_div(CLK_FREQ, BAUD);
   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

   uart_state_t          state_reg;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] shift_next;
   logic [2:0]           bit_cnt_reg;
   logic                 tx_reg;
   logic                 ready_reg;
   logic                 done_reg;
   logic                 tick;
   logic                 pre_tick;
   logic                 accept;

   // ready_reg is only ever high in IDLE, so it alone qualifies an accept.
   assign accept = valid && ready_reg;

   // Bit counter is idle-cleared, so it starts from 0 on every accept.
   baud_tick #(
      .DIV (DIV)
   ) u_baud_tick (
      .clk      (clk),
      .rst      (rst),
      .clr      (state_reg == S_IDLE),
      .tick     (tick),
      .pre_tick (pre_tick)
   );

   // Right shift, filling with the idle level.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
         if (gi == DATA_BITS - 1) begin : g_top
            assign shift_next[gi] = 1'b1;
         end else begin : g_mid
            assign shift_next[gi] = shift_reg[gi+1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= S_IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         tx_reg      <= 1'b1;
         ready_reg   <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               tx_reg <= 1'b1;
               if (accept) begin
                  shift_reg   <= data;
                  bit_cnt_reg <= '0;
                  state_reg   <= S_START;
                  tx_reg      <= 1'b0;
                  ready_reg   <= 1'b0;
               end else begin
                  ready_reg <= 1'b1;
               end
            end
            S_START: begin
               if (tick) begin
                  state_reg <= S_DATA;
                  tx_reg    <= shift_reg[0];
               end
            end
            S_DATA: begin
               if (tick) begin
                  shift_reg   <= shift_next;
                  bit_cnt_reg <= bit_cnt_reg + 1'b1;
                  if (bit_cnt_reg == BIT_LAST) begin
                     state_reg <= S_STOP;
                     tx_reg    <= 1'b1;
                  end else begin
                     tx_reg <= shift_next[0];
                  end
               end
            end
            S_STOP: begin
               // Loaded one cycle early so done coincides with count DIV-1.
               done_reg <= pre_tick;
               if (tick) begin
                  state_reg <= S_IDLE;
                  ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign ready = ready_reg;
   assign tx    = tx_reg;
   assign done  = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed self-checking bench for uart_tx at DIV=16
// (CLK_FREQ=16, BAUD=1). Outputs are sampled on the falling clock edge.
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic       valid;
   logic [7:0] data;
   logic       ready;
   logic       tx;
   logic       done;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   int frame_err = 0;
   time start_t;
   time stop_t;

   logic [7:0] rx_q[$];
   logic       mon_busy = 1'b0;
   int         mon_cnt  = 0;
   logic [7:0] mon_byte = 8'h00;

   uart_tx #(
      .CLK_FREQ (16),
      .BAUD     (1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .valid (valid),
      .data  (data),
      .ready (ready),
      .tx    (tx),
      .done  (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
   end

   // Line decoder: samples each bit in its middle, relative to the first low sample.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         mon_busy <= 1'b0;
      end else if (!mon_busy) begin
         if (tx === 1'b0) begin
            mon_busy <= 1'b1;
            mon_cnt  <= 1;
         end
      end else begin
         mon_cnt <= mon_cnt + 1;
         if (mon_cnt >= 24 && mon_cnt < 152 && (mon_cnt % 16) == 8)
            mon_byte[3'(mon_cnt / 16 - 1)] <= tx;
         if (mon_cnt == 152) begin
            mon_busy <= 1'b0;
            if (tx === 1'b1) rx_q.push_back(mon_byte);
            else frame_err <= frame_err + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      int n = 0;
      while (ready !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 32'(ready), 32'd1);
   endtask

   // Entered between the accepting rising edge and the next falling edge.
   // mode 0: plain, 1: hold valid and switch data to nd, 2: busy disturbance,
   // 3: assert reset during data bit 4 and return.
   task automatic run_frame(input logic [7:0] b, input int mode, input logic [7:0] nd);
      logic expbit;
      for (int j = 0; j < 10; j++) begin
         for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (j == 0 && c == 0) begin
               start_t = $time;
               if (mode != 1) valid = 1'b0;
            end
            if (j == 9 && c == 0) stop_t = $time;
            if (j == 0) expbit = 1'b0;
            else if (j == 9) expbit = 1'b1;
            else expbit = b[j-1];
            chk($sformatf("tx_%02h_b%0d_c%0d", b, j, c), 32'(tx), 32'(expbit));
            chk($sformatf("done_%02h_b%0d_c%0d", b, j, c), 32'(done), 32'(j == 9 && c == 15));
            chk($sformatf("ready_%02h_b%0d_c%0d", b, j, c), 32'(ready), 32'd0);
            if (mode == 1 && j == 5 && c == 0) data = nd;
            if (mode == 2 && j == 4 && c == 3) begin
               data  = 8'hFF;
               valid = 1'b1;
            end
            if (mode == 2 && j == 4 && c == 4) valid = 1'b0;
            if (mode == 3 && j == 5 && c == 3) begin
               rst = 1'b0;
               return;
            end
         end
      end
      @(negedge clk);
      chk($sformatf("end_ready_%02h", b), 32'(ready), 32'd1);
      chk($sformatf("end_tx_%02h", b), 32'(tx), 32'd1);
      chk($sformatf("end_done_%02h", b), 32'(done), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   d0;
      int   idx;
      int   guard;
      int   high_bad;
      time  first_stop;
      string s;

      // Reset release
      rst = 1'b0;
      valid = 1'b0;
      data = 8'h00;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         chk("rst_tx", 32'(tx), 32'd1);
         chk("rst_ready", 32'(ready), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("rel_ready", 32'(ready), 32'd1);
      chk("rel_tx", 32'(tx), 32'd1);
      chk("rel_done_cnt", 32'(done_cnt), 32'd0);

      // Single byte 'h'
      rx_q.delete();
      d0 = done_cnt;
      wait_ready();
      data = 8'h68;
      valid = 1'b1;
      @(posedge clk);
      run_frame(8'h68, 0, 8'h00);
      chk("h_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("h_rx_n", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) chk("h_rx0", 32'(rx_q[0]), 32'h68);

      // Back-to-back with valid held
      rx_q.delete();
      d0 = done_cnt;
      wait_ready();
      data = 8'h69;
      valid = 1'b1;
      @(posedge clk);
      run_frame(8'h69, 1, 8'h74);
      first_stop = stop_t;
      @(posedge clk);
      run_frame(8'h74, 0, 8'h00);
      chk("b2b_gap", 32'((start_t - first_stop) / 10), 32'd17);
      chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
      chk("b2b_rx_n", 32'(rx_q.size()), 32'd2);
      if (rx_q.size() > 1) begin
         chk("b2b_rx0", 32'(rx_q[0]), 32'h69);
         chk("b2b_rx1", 32'(rx_q[1]), 32'h74);
      end

      // Busy-ignore
      rx_q.delete();
      d0 = done_cnt;
      wait_ready();
      data = 8'h73;
      valid = 1'b1;
      @(posedge clk);
      run_frame(8'h73, 2, 8'h00);
      high_bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (tx !== 1'b1 || ready !== 1'b1) high_bad++;
      end
      chk("busy_idle_after", 32'(high_bad), 32'd0);
      chk("busy_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("busy_rx_n", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) chk("busy_rx0", 32'(rx_q[0]), 32'h73);

      // Reset mid-frame
      rx_q.delete();
      d0 = done_cnt;
      wait_ready();
      data = 8'h7A;
      valid = 1'b1;
      @(posedge clk);
      run_frame(8'h7A, 3, 8'h00);
      @(negedge clk);
      chk("mid_rst_tx", 32'(tx), 32'd1);
      chk("mid_rst_done", 32'(done), 32'd0);
      chk("mid_rst_ready", 32'(ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rel_ready", 32'(ready), 32'd1);
      high_bad = 0;
      repeat (80) begin
         @(negedge clk);
         if (tx !== 1'b1 || done !== 1'b0) high_bad++;
      end
      chk("mid_line_quiet", 32'(high_bad), 32'd0);
      chk("mid_done_cnt", 32'(done_cnt - d0), 32'd0);
      chk("mid_rx_n", 32'(rx_q.size()), 32'd0);
      data = 8'h32;
      valid = 1'b1;
      @(posedge clk);
      run_frame(8'h32, 0, 8'h00);
      chk("mid_after_rx_n", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) chk("mid_after_rx0", 32'(rx_q[0]), 32'h32);

      // Upstream string selector advancing on done
      s = "hitsz2024311259";
      rx_q.delete();
      d0 = done_cnt;
      idx = 0;
      guard = 0;
      data = s[0];
      valid = 1'b1;
      while (idx < 15 && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (done === 1'b1) begin
            idx++;
            if (idx < 15) data = s[idx];
            else valid = 1'b0;
         end
      end
      valid = 1'b0;
      repeat (20) @(negedge clk);
      chk("str_idx", 32'(idx), 32'd15);
      chk("str_done_cnt", 32'(done_cnt - d0), 32'd15);
      chk("str_rx_n", 32'(rx_q.size()), 32'd15);
      for (int i = 0; i < 15 && i < rx_q.size(); i++)
         chk($sformatf("str_rx%0d", i), 32'(rx_q[i]), 32'(s[i]));
      chk("frame_err", 32'(frame_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
